// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one external FP32 adder
//
// Purpose:
//   Lets NUM_REQ requesters share one combinational FP32 adder. One request
//   is granted at a time, round-robin. The winner's operands are held on the
//   adder for ADD_LAT cycles, then the sum is captured bit-exact. The sum is
//   returned with the requester id over a valid/ready response channel.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester request handshake (ready is one-hot)
//   req_a, req_b        packed operands, requester i at [32i+31:32i]
//   add_a/b/valid       drive to the shared adder
//   add_sum             adder result, sampled on the last hold cycle only
//   rsp_valid/ready     response handshake
//   rsp_id, rsp_sum     requester index and captured sum
//   busy                high while an operation is in EXEC or RESP

module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 2,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_valid,
  input  logic [31:0]           add_sum,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_sum,
  input  logic                  rsp_ready,
  output logic                  busy
);

  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       id;
  logic [CW-1:0]        cnt;

  logic [31:0]          op_a [NUM_REQ];
  logic [31:0]          op_b [NUM_REQ];
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_found;
  logic [IDW-1:0]       grant_idx;
  logic [IDW-1:0]       grant_next;
  int                   grant_pos;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_a[i] = req_a[32*i +: 32];
    assign op_b[i] = req_b[32*i +: 32];
  end

  // Rotating a doubled copy puts requester rr_ptr at bit 0, so the first set
  // bit of valid_rot is the round-robin winner's offset from rr_ptr.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = NUM_REQ'(valid_dbl >> rr_ptr);

  always_comb begin
    grant_found = 1'b0;
    grant_pos   = 0;
    // Downward scan: the lowest offset is written last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_found = 1'b1;
        grant_pos   = int'(rr_ptr) + k;
      end
    end
    if (grant_pos >= NUM_REQ) begin
      grant_pos = grant_pos - NUM_REQ;
    end
    grant_idx  = IDW'(grant_pos);
    grant_next = (grant_pos == NUM_REQ - 1) ? '0 : IDW'(grant_pos + 1);
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            add_a     <= op_a[grant_idx];
            add_b     <= op_b[grant_idx];
            add_valid <= 1'b1;
            id        <= grant_idx;
            cnt       <= CW'(ADD_LAT - 1);
            rr_ptr    <= grant_next;
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            // Last hold cycle: the adder output has settled.
            rsp_sum   <= add_sum;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            add_valid <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          // Going back through IDLE leaves a one-cycle gap before the next grant.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;
  localparam int N = 4;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: four requesters, two-cycle adder
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_a, req_b;
  logic [N-1:0]      req_ready;
  logic [31:0]       add_a, add_b;
  logic              add_valid;
  wire  [31:0]       add_sum;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_sum;
  logic              rsp_ready;
  logic              busy;

  // Small instance: one requester, one-cycle adder
  logic              s_rst;
  logic [0:0]        s_req_valid;
  logic [31:0]       s_req_a, s_req_b;
  logic [0:0]        s_req_ready;
  logic [31:0]       s_add_a, s_add_b;
  logic              s_add_valid;
  wire  [31:0]       s_add_sum;
  logic              s_rsp_valid;
  logic [0:0]        s_rsp_id;
  logic [31:0]       s_rsp_sum;
  logic              s_rsp_ready;
  logic              s_busy;

  fp_add_arbiter #(.NUM_REQ(N), .ADD_LAT(L), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_sum(add_sum), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  fp_add_arbiter #(.NUM_REQ(1), .ADD_LAT(1), .IDW(1)) dut_s (
    .clk(clk), .rst(s_rst), .req_valid(s_req_valid), .req_a(s_req_a), .req_b(s_req_b),
    .req_ready(s_req_ready), .add_a(s_add_a), .add_b(s_add_b), .add_valid(s_add_valid),
    .add_sum(s_add_sum), .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_sum(s_rsp_sum),
    .rsp_ready(s_rsp_ready), .busy(s_busy)
  );

  // Reference adder through real arithmetic (exact for small integers)
  function automatic real fp32_to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
  endfunction

  // Integer to FP32 encoding for the scoreboard (|n| < 2^24)
  function automatic logic [31:0] int_to_fp32(input int n);
    int mag;
    int p;
    logic [31:0] m32;
    logic [7:0]  e;
    if (n == 0) return 32'd0;
    mag = (n < 0) ? -n : n;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
    m32 = 32'(mag) << (23 - p);
    e = 8'(127 + p);
    return {(n < 0) ? 1'b1 : 1'b0, e, m32[22:0]};
  endfunction

  // The adder output only becomes the true sum after L-1 hold cycles; earlier it is garbage.
  int hold_m = 0;
  always @(posedge clk) hold_m <= add_valid ? hold_m + 1 : 0;
  assign add_sum = !add_valid ? 32'hzzzzzzzz :
                   (hold_m >= L - 1) ? fp32_add(add_a, add_b) : 32'hDEADBEEF;
  assign s_add_sum = s_add_valid ? fp32_add(s_add_a, s_add_b) : 32'hzzzzzzzz;

  // Behavioural model state
  int model_ptr;
  int ia [N];
  int ib [N];

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = int_to_fp32(ia[i]);
      req_b[32*i +: 32] = int_to_fp32(ib[i]);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ia[i] = int'($urandom_range(0, 2000)) - 1000;
      ib[i] = int'($urandom_range(0, 2000)) - 1000;
    end
    pack_ops();
  endtask

  task automatic wait_grant(input int limit, output int g, output bit ok);
    ok = 1'b0;
    g = -1;
    for (int t = 0; t < limit; t++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_rst = 1'b1;
    req_valid = '0; s_req_valid = '0;
    rsp_ready = 1'b0; s_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({add_valid, rsp_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {add_valid, rsp_valid, busy});
    end
    checks++;
    if (add_a !== 32'd0 || add_b !== 32'd0 || rsp_sum !== 32'd0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h %0d want zeros", add_a, add_b, rsp_sum, rsp_id);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    rsp_ready = 1'b0;
    req_a[95:64] = 32'h3F800000;
    req_b[95:64] = 32'h40000000;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b0000 || add_valid !== 1'b1 || add_a !== 32'h3F800000 ||
        add_b !== 32'h40000000 || busy !== 1'b1) begin
      errors++; $display("FAIL single_exec1 got rdy=%b av=%b a=%h b=%h busy=%b want 0000 1 3f800000 40000000 1",
                         req_ready, add_valid, add_a, add_b, busy);
    end
    @(negedge clk);
    checks++;
    if (add_valid !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_exec2 got av=%b rv=%b want 1 0", add_valid, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h40400000) begin
      errors++; $display("FAIL single_rsp got v=%b id=%0d sum=%h want 1 2 40400000", rsp_valid, rsp_id, rsp_sum);
    end
    checks++;
    if (add_valid !== 1'b0 || add_a !== 32'd0 || add_b !== 32'd0) begin
      errors++; $display("FAIL single_adder_off got av=%b a=%h b=%h want 0 0 0", add_valid, add_a, add_b);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done got rv=%b busy=%b want 0 0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
    model_ptr = 3;
  endtask

  task automatic test_all_rr();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int g;
    int last;
    bit ok;
    logic [31:0] exp_sum;
    do_reset();
    rand_ops();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    last = 0;
    for (int n = 0; n < 6; n++) begin
      wait_grant(20, g, ok);
      checks++;
      if (!ok || g != order[n]) begin
        errors++; $display("FAIL rr_order n=%0d got %0d want %0d", n, g, order[n]);
      end
      if (n > 0) begin
        checks++;
        if (cyc - last != L + 2) begin
          errors++; $display("FAIL rr_spacing n=%0d got %0d want %0d", n, cyc - last, L + 2);
        end
      end
      last = cyc;
      exp_sum = int_to_fp32(ia[order[n]] + ib[order[n]]);
      model_ptr = (order[n] + 1) % N;
      @(negedge clk);
      ia[order[n]] = int'($urandom_range(0, 2000)) - 1000;
      ib[order[n]] = int'($urandom_range(0, 2000)) - 1000;
      pack_ops();
      repeat (L) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[n]) || rsp_sum !== exp_sum) begin
        errors++; $display("FAIL rr_rsp n=%0d got v=%b id=%0d sum=%h want 1 %0d %h",
                           n, rsp_valid, rsp_id, rsp_sum, order[n], exp_sum);
      end
    end
    req_valid = '0;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_pair();
    int g;
    bit ok;
    do_reset();
    rand_ops();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    wait_grant(10, g, ok);
    checks++;
    if (!ok || g != 1) begin
      errors++; $display("FAIL pair_setup got %0d want 1", g);
    end
    @(negedge clk);
    req_valid = 4'b1010;
    wait_grant(20, g, ok);
    checks++;
    if (!ok || g != 3) begin
      errors++; $display("FAIL pair_first got %0d want 3", g);
    end
    @(negedge clk);
    wait_grant(20, g, ok);
    checks++;
    if (!ok || g != 1) begin
      errors++; $display("FAIL pair_second got %0d want 1", g);
    end
    req_valid = '0;
    repeat (L + 3) @(negedge clk);
    rsp_ready = 1'b0;
    model_ptr = 2;
  endtask

  task automatic test_backpressure();
    int g;
    bit ok;
    logic [31:0] exp_sum;
    rand_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_grant(10, g, ok);
    checks++;
    if (!ok || g != rr_pick(model_ptr, 4'b0001)) begin
      errors++; $display("FAIL bp_grant got %0d want 0", g);
    end
    model_ptr = 1;
    exp_sum = int_to_fp32(ia[0] + ib[0]);
    @(negedge clk);
    req_valid = 4'b1111;
    repeat (L) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== exp_sum || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold i=%0d got v=%b id=%0d sum=%h rdy=%b want 1 0 %h 0000",
                           i, rsp_valid, rsp_id, rsp_sum, req_ready, exp_sum);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_release got rv=%b rdy=%b want 0 0010", rsp_valid, req_ready);
    end
    req_valid = '0;
    repeat (L + 3) @(negedge clk);
    rsp_ready = 1'b0;
    model_ptr = 2;
  endtask

  task automatic test_reset_mid();
    int g;
    bit ok;
    int seen;
    rand_ops();
    req_valid = 4'b0100;
    wait_grant(10, g, ok);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (add_valid !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || add_a !== 32'd0) begin
      errors++; $display("FAIL midrst_state got av=%b rv=%b busy=%b a=%h want 0 0 0 0",
                         add_valid, rsp_valid, busy, add_a);
    end
    rsp_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_norsp got %0d responses want 0", seen);
    end
    model_ptr = 0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_ptr got %b want 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL drop_noeffect got %b want 0010", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    int g;
    int exp;
    bit ok;
    logic [N-1:0] mask;
    logic [31:0] exp_sum;
    do_reset();
    for (int n = 0; n < 25; n++) begin
      rand_ops();
      mask = N'($urandom_range(1, 15));
      req_valid = mask;
      rsp_ready = 1'b0;
      exp = rr_pick(model_ptr, mask);
      exp_sum = int_to_fp32(ia[exp] + ib[exp]);
      wait_grant(10, g, ok);
      checks++;
      if (!ok || g != exp) begin
        errors++; $display("FAIL rand_grant n=%0d mask=%b got %0d want %0d", n, mask, g, exp);
      end
      model_ptr = (exp + 1) % N;
      @(negedge clk);
      req_valid = N'($urandom_range(0, 15));
      rand_ops();
      repeat (L) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_sum !== exp_sum) begin
        errors++; $display("FAIL rand_rsp n=%0d got v=%b id=%0d sum=%h want 1 %0d %h",
                           n, rsp_valid, rsp_id, rsp_sum, exp, exp_sum);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rand_ack n=%0d got %b want 0", n, rsp_valid);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_small();
    int last;
    int t;
    s_rsp_ready = 1'b1;
    s_req_a = 32'hC0000000;
    s_req_b = 32'h3F800000;
    s_req_valid = 1'b1;
    #1;
    checks++;
    if (s_req_ready !== 1'b1) begin
      errors++; $display("FAIL small_grant got %b want 1", s_req_ready);
    end
    last = cyc;
    @(negedge clk);
    checks++;
    if (s_add_valid !== 1'b1 || s_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL small_exec got av=%b rv=%b want 1 0", s_add_valid, s_rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (s_rsp_valid !== 1'b1 || s_rsp_sum !== 32'hBF800000 || s_rsp_id !== 1'b0) begin
      errors++; $display("FAIL small_rsp got v=%b sum=%h id=%0d want 1 bf800000 0",
                         s_rsp_valid, s_rsp_sum, s_rsp_id);
    end
    for (int n = 0; n < 3; n++) begin
      t = 0;
      @(negedge clk);
      #1;
      while (s_req_ready !== 1'b1 && t < 10) begin
        @(negedge clk);
        #1;
        t++;
      end
      checks++;
      if (t >= 10 || cyc - last != 3) begin
        errors++; $display("FAIL small_spacing n=%0d got %0d want 3", n, cyc - last);
      end
      last = cyc;
    end
    s_req_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    s_req_valid = '0; s_req_a = '0; s_req_b = '0; s_rsp_ready = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_all_rr();
    test_pair();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
